// File: rtl/dma_w_burst_ctrl.sv
// dma_w_burst_ctrl
//
// Sequencer in front of the AXI DMA write engine. Takes one write descriptor
// (beat-aligned start address + total beat count), splits it into INCR bursts
// of at most MAX_BURST beats that never cross a 4 KB boundary, and streams
// requester beats through to the write engine. done pulses for one cycle
// after the last beat of the descriptor has been handed over.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cmd_valid/ready   descriptor handshake (ready = controller idle)
//   cmd_addr          start byte address (low log2(BYTES) bits ignored)
//   cmd_beats         total beats, 0 allowed
//   s_valid/ready     requester beat handshake
//   s_data/s_strb     requester data and byte strobes
//   dma_valid/ready   beat handshake toward the write engine
//   dma_addr/dma_len  current burst start address and beats-1 (stable per burst)
//   dma_wdata/wstrb   pass-through of s_data/s_strb
//   dma_last          current beat closes its burst
//   busy              descriptor in progress
//   done              one-cycle completion pulse
module dma_w_burst_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256,
    parameter int LEN_W     = 8,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [CNT_W-1:0]      cmd_beats,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_data,
    input  logic [DATA_W/8-1:0]   s_strb,
    output logic                  dma_valid,
    input  logic                  dma_ready,
    output logic [ADDR_W-1:0]     dma_addr,
    output logic [LEN_W-1:0]      dma_len,
    output logic [DATA_W-1:0]     dma_wdata,
    output logic [DATA_W/8-1:0]   dma_wstrb,
    output logic                  dma_last,
    output logic                  busy,
    output logic                  done
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF   = $clog2(BYTES);
    // Common width for the min() of MAX_BURST, left and to_bnd.
    localparam int MW    = (CNT_W > 13) ? CNT_W + 1 : 14;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, CALC, BURST, DONE} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cur_addr_q;
    logic [ADDR_W-1:0]   dma_addr_q;
    logic [CNT_W-1:0]    left_q;
    logic [LEN_W-1:0]    dma_len_q;
    logic [LEN_W-1:0]    bcnt_q;
    logic                cmd_ready_q;
    logic                busy_q;
    logic                done_q;

    logic [12:0]         to_bnd;
    logic [MW-1:0]       blen;
    logic                in_burst;
    logic                beat_xfer;
    logic                burst_end;
    logic [ADDR_W-1:0]   burst_bytes;

    // Burst length for the next burst, consumed in CALC.
    always_comb begin
        to_bnd = (13'h1000 - {1'b0, cur_addr_q[11:0]}) >> OFF;
        blen   = MW'(MAX_BURST);
        if (MW'(left_q) < blen) begin
            blen = MW'(left_q);
        end
        if (MW'(to_bnd) < blen) begin
            blen = MW'(to_bnd);
        end
    end

    assign in_burst    = (state_q == BURST);
    assign beat_xfer   = in_burst && s_valid && dma_ready;
    assign burst_end   = beat_xfer && (bcnt_q == dma_len_q);
    // Byte size of the current burst; dma_len_q + 1 is its beat count.
    assign burst_bytes = ADDR_W'({1'b0, dma_len_q} + {{LEN_W{1'b0}}, 1'b1}) << OFF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            dma_addr_q  <= '0;
            left_q      <= '0;
            dma_len_q   <= '0;
            bcnt_q      <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    // cmd_ready_q is still 0 in the first cycle after reset,
                    // so acceptance is gated by it rather than by the state.
                    if (cmd_ready_q && cmd_valid) begin
                        cur_addr_q  <= cmd_addr & ALIGN_MASK;
                        left_q      <= cmd_beats;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cmd_beats == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    dma_addr_q <= cur_addr_q;
                    dma_len_q  <= LEN_W'(blen - MW'(1));
                    bcnt_q     <= '0;
                    state_q    <= BURST;
                end
                BURST: begin
                    if (beat_xfer) begin
                        bcnt_q <= bcnt_q + 1'b1;
                        left_q <= left_q - 1'b1;
                    end
                    if (burst_end) begin
                        cur_addr_q <= cur_addr_q + burst_bytes;
                        if (left_q == CNT_W'(1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                DONE: begin
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dma_addr  = dma_addr_q;
    assign dma_len   = dma_len_q;
    assign dma_valid = in_burst && s_valid;
    assign s_ready   = in_burst && dma_ready;
    assign dma_last  = in_burst && (bcnt_q == dma_len_q);
    assign dma_wdata = s_data;
    assign dma_wstrb = s_strb;

endmodule
